// File: rtl/srv_ifill_pkg.sv
// Shared types and constants for the instruction line-fill unit.
// A line is four 32-bit words fetched one beat at a time.
package srv_ifill_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RESP = 2'd2
   } ifill_state_t;

   localparam int LINE_WORDS = 4;
   localparam int LINE_W     = 128;
   localparam int BEAT_W     = 2;
   localparam int WORD_W     = 32;

   localparam logic [31:0] LINE_MASK = 32'hFFFF_FFFC;

   // Line base of a word address: the two beat-select bits are forced to zero.
   function automatic logic [31:0] line_base(input logic [31:0] addr);
      return addr & LINE_MASK;
   endfunction

endpackage

// File: rtl/srv_ifill.sv
// Line-fill unit: turns one line request into four sequential word reads and
// returns the assembled 128-bit line, with an optional last-line bypass buffer.
module srv_ifill
   import srv_ifill_pkg::*;
#(
   parameter bit BUF_EN = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ext_req_i,
   input  logic [31:0]   ext_addr_i,
   output logic          ext_rsp_o,
   output logic [127:0]  ext_data_o,
   output logic          busy_o,
   output logic          mem_req_o,
   output logic [31:0]   mem_addr_o,
   input  logic          mem_ack_i,
   input  logic [31:0]   mem_rdata_i
);

   ifill_state_t        r_state;
   logic [31:0]         r_line_addr;
   logic [BEAT_W-1:0]   r_beat;
   logic [31:0]         r_buf_addr;
   logic                r_buf_valid;
   logic                r_rsp;
   logic                r_busy;
   logic                r_mem_req;
   logic [LINE_W-1:0]   r_line;

   logic [31:0]         w_req_line;
   logic                w_hit;
   logic                w_beat_ack;

   assign w_req_line = line_base(ext_addr_i);
   assign w_hit      = BUF_EN && r_buf_valid && (w_req_line == r_buf_addr);
   // Acks outside FILL must never touch the beat counter or the line register.
   assign w_beat_ack = (r_state == FILL) && mem_ack_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_line_addr <= '0;
         r_beat      <= '0;
         r_buf_addr  <= '0;
         r_buf_valid <= 1'b0;
         r_rsp       <= 1'b0;
         r_busy      <= 1'b0;
         r_mem_req   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (ext_req_i) begin
                  r_line_addr <= w_req_line;
                  r_busy      <= 1'b1;
                  if (w_hit) begin
                     r_state <= RESP;
                     r_rsp   <= 1'b1;
                  end else begin
                     // The line register is about to be overwritten, so the
                     // buffered copy stops being valid right now.
                     r_beat      <= '0;
                     r_buf_valid <= 1'b0;
                     r_state     <= FILL;
                     r_mem_req   <= 1'b1;
                  end
               end
            end
            FILL: begin
               if (mem_ack_i) begin
                  r_beat <= r_beat + 2'd1;
                  if (r_beat == 2'd3) begin
                     if (BUF_EN) begin
                        r_buf_addr  <= r_line_addr;
                        r_buf_valid <= 1'b1;
                     end
                     r_mem_req <= 1'b0;
                     r_rsp     <= 1'b1;
                     r_state   <= RESP;
                  end
               end
            end
            RESP: begin
               r_rsp   <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_rsp     <= 1'b0;
               r_busy    <= 1'b0;
               r_mem_req <= 1'b0;
               r_state   <= IDLE;
            end
         endcase
      end
   end

   // Line register doubles as the bypass buffer payload.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_line <= '0;
      end else if (w_beat_ack) begin
         r_line[r_beat*WORD_W +: WORD_W] <= mem_rdata_i;
      end
   end

   assign ext_rsp_o  = r_rsp;
   assign ext_data_o = r_line;
   assign busy_o     = r_busy;
   assign mem_req_o  = r_mem_req;
   assign mem_addr_o = r_line_addr | {30'd0, r_beat};

endmodule

// File: tb/tb_srv_ifill.sv
// Scoreboard bench for srv_ifill: one instance with the bypass buffer and one
// without, sharing a wait-state-programmable memory model.
module tb_srv_ifill;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req;
   logic [31:0]   addr;
   int            sel;
   logic          stray;
   int            dur;
   int            cyc = 0;
   int            wcnt;

   logic          req0, rsp0, busy0, mreq0, ack0;
   logic [31:0]   maddr0;
   logic [127:0]  data0;
   logic          req1, rsp1, busy1, mreq1, ack1;
   logic [31:0]   maddr1;
   logic [127:0]  data1;
   logic [31:0]   rdata;

   logic          m_rsp, m_busy, m_req, m_ack, ack_now;
   logic [31:0]   m_addr;
   logic [127:0]  m_data;

   int            exp_cyc[$];
   logic [127:0]  exp_line[$];
   logic [31:0]   exp_addr[$];
   int            n_chk = 0;
   int            n_fail = 0;
   int            n_ack = 0;

   logic          p_req, p_ack;
   logic [31:0]   p_addr;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a + 32'h90;
   endfunction

   function automatic logic [127:0] line_of(input logic [31:0] a);
      logic [31:0] b;
      b = {a[31:2], 2'b00};
      return {mem_word(b + 32'd3), mem_word(b + 32'd2), mem_word(b + 32'd1), mem_word(b)};
   endfunction

   srv_ifill #(.BUF_EN(1'b1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .ext_req_i(req0), .ext_addr_i(addr),
      .ext_rsp_o(rsp0), .ext_data_o(data0), .busy_o(busy0),
      .mem_req_o(mreq0), .mem_addr_o(maddr0), .mem_ack_i(ack0), .mem_rdata_i(rdata)
   );

   srv_ifill #(.BUF_EN(1'b0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .ext_req_i(req1), .ext_addr_i(addr),
      .ext_rsp_o(rsp1), .ext_data_o(data1), .busy_o(busy1),
      .mem_req_o(mreq1), .mem_addr_o(maddr1), .mem_ack_i(ack1), .mem_rdata_i(rdata)
   );

   assign req0    = req && (sel == 0);
   assign req1    = req && (sel == 1);
   assign m_rsp   = (sel == 1) ? rsp1  : rsp0;
   assign m_busy  = (sel == 1) ? busy1 : busy0;
   assign m_req   = (sel == 1) ? mreq1 : mreq0;
   assign m_addr  = (sel == 1) ? maddr1 : maddr0;
   assign m_data  = (sel == 1) ? data1 : data0;
   assign m_ack   = (sel == 1) ? ack1  : ack0;
   assign ack_now = stray || (m_req && (wcnt >= dur - 1));
   assign ack0    = ack_now && (sel == 0);
   assign ack1    = ack_now && (sel == 1);
   assign rdata   = mem_word(m_addr);

   // Each beat is acked on its dur-th request cycle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) wcnt <= 0;
      else        wcnt <= (m_req && !m_ack) ? wcnt + 1 : 0;
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      int           ec;
      logic [127:0] el;
      if (rst_n) begin
         if (m_req && p_req && !p_ack) chk("addr_hold", 128'(m_addr), 128'(p_addr));
         if (m_req && m_ack) begin
            if (exp_addr.size() == 0) chk("mem_unexp", 128'd1, 128'd0);
            else chk("mem_addr", 128'(m_addr), 128'(exp_addr.pop_front()));
            n_ack++;
         end
         if (m_rsp) begin
            if (exp_cyc.size() == 0) begin
               chk("rsp_unexp", 128'd1, 128'd0);
            end else begin
               ec = exp_cyc.pop_front();
               el = exp_line.pop_front();
               $display("rsp inst=%0d cyc=%0d line=%h", sel, cyc, m_data);
               chk("rsp_cyc", 128'(cyc), 128'(ec));
               chk("rsp_line", m_data, el);
            end
         end
      end
      p_req  <= m_req && rst_n;
      p_ack  <= m_ack;
      p_addr <= m_addr;
   end

   task automatic wait_idle();
      int t;
      t = 0;
      @(negedge clk);
      while ((m_busy || m_rsp) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) chk("idle_timeout", 128'd1, 128'd0);
   endtask

   task automatic flush();
      exp_cyc.delete();
      exp_line.delete();
      exp_addr.delete();
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while ((exp_cyc.size() != 0 || exp_addr.size() != 0) && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) begin
         chk("done_timeout", 128'd1, 128'd0);
         flush();
      end
   endtask

   task automatic push_req(input logic [31:0] a, input bit miss, input int at);
      exp_cyc.push_back(at);
      exp_line.push_back(line_of(a));
      if (miss) for (int k = 0; k < 4; k++) exp_addr.push_back({a[31:2], 2'(k)});
   endtask

   task automatic do_req(input logic [31:0] a, input bit miss, input int lat);
      wait_idle();
      addr = a;
      req  = 1'b1;
      push_req(a, miss, cyc + lat);
      @(posedge clk);
      #1 req = 1'b0;
      wait_done();
   endtask

   // Keep the request high until the negedge of cycle 'upto', then drop it.
   task automatic hold_until(input int upto);
      int t;
      t = 0;
      while (cyc < upto && t < 200) begin
         @(negedge clk);
         t++;
      end
      req = 1'b0;
   endtask

   initial begin : stim
      int           c;
      int           a0;
      logic [127:0] d;
      rst_n = 1'b0;
      req   = 1'b0;
      addr  = '0;
      sel   = 0;
      stray = 1'b0;
      dur   = 1;
      #12;
      chk("rst_rsp0",  128'(rsp0), 128'd0);
      chk("rst_busy0", 128'(busy0), 128'd0);
      chk("rst_req0",  128'(mreq0), 128'd0);
      chk("rst_addr0", 128'(maddr0), 128'd0);
      chk("rst_data0", data0, 128'd0);
      chk("rst_busy1", 128'(busy1), 128'd0);
      chk("rst_req1",  128'(mreq1), 128'd0);
      chk("rst_data1", data1, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Wait states: three cycles per beat.
      dur = 3;
      do_req(32'h44, 1'b1, 13);
      dur = 1;

      // Zero-wait miss with the documented data pattern.
      do_req(32'h10, 1'b1, 5);
      chk("t1_line", data0, 128'h000000A3_000000A2_000000A1_000000A0);

      // Bypass hit on a different word of the same line, then a new line.
      do_req(32'h13, 1'b0, 1);
      do_req(32'h20, 1'b1, 5);
      do_req(32'h11, 1'b1, 5);

      // Held request on a buffered line: back-to-back hits, two cycles apart.
      wait_idle();
      c = cyc;
      addr = 32'h12;
      req  = 1'b1;
      push_req(32'h12, 1'b0, c + 1);
      push_req(32'h12, 1'b0, c + 3);
      hold_until(c + 3);
      wait_done();

      // Stray ack while idle must leave everything untouched.
      wait_idle();
      d = data0;
      stray = 1'b1;
      @(negedge clk);
      stray = 1'b0;
      chk("stray_busy", 128'(busy0), 128'd0);
      chk("stray_req",  128'(mreq0), 128'd0);
      chk("stray_data", data0, d);
      do_req(32'h10, 1'b0, 1);

      // Reset after beat 1 of a wait-state fill.
      dur = 3;
      wait_idle();
      c  = cyc;
      a0 = n_ack;
      addr = 32'h30;
      req  = 1'b1;
      push_req(32'h30, 1'b1, c + 13);
      @(posedge clk);
      #1 req = 1'b0;
      while (cyc < c + 7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_acks", 128'(n_ack - a0), 128'd2);
      chk("mrst_rsp",  128'(rsp0), 128'd0);
      chk("mrst_busy", 128'(busy0), 128'd0);
      chk("mrst_req",  128'(mreq0), 128'd0);
      chk("mrst_addr", 128'(maddr0), 128'd0);
      chk("mrst_data", data0, 128'd0);
      flush();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      dur = 1;
      do_req(32'h30, 1'b1, 5);

      // Reset while idle drops the buffered line.
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      do_req(32'h31, 1'b1, 5);
      do_req(32'h50, 1'b1, 5);

      // No bypass buffer: identical requests always fill.
      sel = 1;
      do_req(32'h10, 1'b1, 5);
      do_req(32'h10, 1'b1, 5);
      wait_idle();
      c = cyc;
      addr = 32'h10;
      req  = 1'b1;
      push_req(32'h10, 1'b1, c + 5);
      push_req(32'h10, 1'b1, c + 11);
      hold_until(c + 11);
      wait_done();
      repeat (8) @(negedge clk);
      chk("tail_idle", 128'(busy1), 128'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
